// File: rtl/udp_ingress_arbiter.sv
// Round-robin, whole-packet arbiter that feeds several byte streams into one udp_parser.
// Packets leave contiguously with a fixed idle gap; underrun and oversize are policed.
module udp_ingress_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_PKT_LEN = 1514
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_data,
  input  logic [NUM_PORTS-1:0]          s_valid,
  input  logic [NUM_PORTS-1:0]          s_last,
  output logic [NUM_PORTS-1:0]          s_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy,
  output logic                          err_underrun,
  output logic                          err_oversize
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [15:0]     LastIdx = 16'(MAX_PKT_LEN - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StGap
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]            byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0]      m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   err_und_q, err_und_d;
  logic                   err_ovr_q, err_ovr_d;

  logic                   arb_hit;
  logic [IdxW-1:0]        arb_win;
  logic                   own_valid;
  logic                   own_last;
  logic [DATA_W-1:0]      own_data;

  // Rotating priority search: first requester at or after rr_ptr wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    cand    = '0;
    arb_hit = 1'b0;
    arb_win = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      cand = IdxW'((32'(rr_ptr_q) + off) % NUM_PORTS);
      if (!arb_hit && s_valid[cand]) begin
        arb_hit = 1'b1;
        arb_win = cand;
      end
    end
  end

  assign own_valid = s_valid[owner_q];
  assign own_last  = s_last[owner_q];
  assign own_data  = s_data[owner_q*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    err_und_d  = 1'b0;
    err_ovr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_hit) begin
          state_d          = StStream;
          grant_d          = '0;
          grant_d[arb_win] = 1'b1;
          owner_d          = arb_win;
          rr_ptr_d         = IdxW'((32'(arb_win) + 1) % NUM_PORTS);
          byte_cnt_d       = '0;
        end
      end

      StStream: begin
        if (!own_valid) begin
          err_und_d = 1'b1;
          state_d   = StGap;
          grant_d   = '0;
          gap_cnt_d = '0;
        end else begin
          m_data_d   = own_data;
          m_valid_d  = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          // A last byte landing exactly on the length limit is a clean end.
          if (own_last) begin
            state_d   = StGap;
            grant_d   = '0;
            gap_cnt_d = '0;
          end else if (byte_cnt_q == LastIdx) begin
            err_ovr_d = 1'b1;
            state_d   = StDrain;
          end
        end
      end

      StDrain: begin
        if (!own_valid || own_last) begin
          state_d   = StGap;
          grant_d   = '0;
          gap_cnt_d = '0;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      err_und_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      err_und_q  <= err_und_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  // grant is only non-zero in STREAM and DRAIN, so it doubles as the ready mask.
  assign s_ready      = grant_q;
  assign grant        = grant_q;
  assign busy         = (state_q != StIdle);
  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign err_underrun = err_und_q;
  assign err_oversize = err_ovr_q;

endmodule

// File: tb/tb_udp_ingress_arbiter.sv
// Bench for udp_ingress_arbiter: directed timing sequences, a single-packet vector table,
// and randomized multi-port traffic checked against a packet-level round-robin model.
module tb_udp_ingress_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 8;
  localparam int GAP  = 2;
  localparam int MAXL = 16;
  localparam int QD   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  s_data;
  logic [NP-1:0]     s_valid;
  logic [NP-1:0]     s_last;
  logic [NP-1:0]     s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic [NP-1:0]     grant;
  logic              busy;
  logic              err_underrun;
  logic              err_oversize;

  always #5 clk = ~clk;

  udp_ingress_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_W     (DW),
    .GAP_CYCLES (GAP),
    .MAX_PKT_LEN(MAXL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .grant       (grant),
    .busy        (busy),
    .err_underrun(err_underrun),
    .err_oversize(err_oversize)
  );

  // Source packet: bytes are base+i; drop>0 means valid falls after 'drop' bytes.
  typedef struct {
    int len;
    int drop;
    int base;
  } pkt_t;

  typedef struct {
    int port;
    int len;
    int drop;
    int base;
    int fwd;
    int ovr;
    int und;
  } vec_t;

  pkt_t src [NP][QD];
  int   head[NP];
  int   cnt [NP];
  int   pos [NP];

  int total = 0;
  int bad   = 0;

  int obs_port[$], obs_len[$], obs_first[$], obs_consec[$];
  int exp_port[$], exp_len[$], exp_first[$];
  int exp_und, exp_ovr;
  int cur_len, cur_first, cur_consec, cur_prev, cur_owner, last_owner;
  bit in_pkt, seen_pkt, prev_und, prev_ovr;
  int idle_run, und_cnt, ovr_cnt, ovr_at_len;
  int viol_onehot = 0, viol_ready = 0, viol_gap = 0, viol_pulse = 0, viol_ovr_valid = 0;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NP-1:0] g);
    for (int i = 0; i < NP; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      head[p] = 0;
      cnt[p]  = 0;
      pos[p]  = 0;
    end
  endtask

  task automatic clear_mon();
    obs_port.delete(); obs_len.delete(); obs_first.delete(); obs_consec.delete();
    in_pkt = 0; seen_pkt = 0; idle_run = 0; und_cnt = 0; ovr_cnt = 0; ovr_at_len = 0;
    last_owner = -1; prev_und = 0; prev_ovr = 0;
  endtask

  task automatic load(input int p, input int len, input int drop, input int base);
    src[p][head[p] + cnt[p]] = '{len, drop, base};
    cnt[p]++;
  endtask

  task automatic drive_inputs();
    pkt_t c;
    for (int p = 0; p < NP; p++) begin
      s_valid[p] = 1'b0;
      s_last[p]  = 1'b0;
      s_data[p*DW +: DW] = '0;
      if (cnt[p] > 0) begin
        c = src[p][head[p]];
        if (!(c.drop > 0 && pos[p] == c.drop)) begin
          s_valid[p] = 1'b1;
          s_data[p*DW +: DW] = DW'(c.base + pos[p]);
          s_last[p] = (pos[p] == c.len - 1);
        end
      end
    end
  endtask

  task automatic monitor();
    int g;
    g = oh_idx(grant);
    if (!$onehot0(grant)) viol_onehot++;
    if ((s_ready & ~grant) != '0) viol_ready++;
    if (g >= 0) last_owner = g;
    if (err_underrun) und_cnt++;
    if (err_oversize) begin
      ovr_cnt++;
      if (!m_valid) viol_ovr_valid++;
    end
    if ((err_underrun && prev_und) || (err_oversize && prev_ovr)) viol_pulse++;
    prev_und = err_underrun;
    prev_ovr = err_oversize;
    if (m_valid) begin
      if (!in_pkt) begin
        if (seen_pkt && idle_run < GAP + 1) viol_gap++;
        in_pkt = 1; cur_len = 0; cur_first = int'(m_data); cur_consec = 1;
        cur_owner = last_owner;
      end else if (m_data != DW'(cur_prev + 1)) begin
        cur_consec = 0;
      end
      cur_prev = int'(m_data);
      cur_len++;
      if (err_oversize) ovr_at_len = cur_len;
    end else begin
      if (in_pkt) begin
        obs_port.push_back(cur_owner);
        obs_len.push_back(cur_len);
        obs_first.push_back(cur_first);
        obs_consec.push_back(cur_consec);
        in_pkt = 0; seen_pkt = 1; idle_run = 0;
      end
      idle_run++;
    end
  endtask

  // One clock: sources advance on what was accepted at the edge, outputs sampled 1 after it.
  task automatic tick();
    logic [NP-1:0] acc;
    logic [NP-1:0] dropping;
    acc = s_valid & s_ready;
    for (int p = 0; p < NP; p++) begin
      dropping[p] = 1'b0;
      if (cnt[p] > 0)
        if (src[p][head[p]].drop > 0 && pos[p] == src[p][head[p]].drop) dropping[p] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && cnt[p] > 0) begin
        pos[p]++;
        if (pos[p] == src[p][head[p]].len) begin
          head[p]++; cnt[p]--; pos[p] = 0;
        end
      end else if (dropping[p]) begin
        head[p]++; cnt[p]--; pos[p] = 0;
      end
    end
    monitor();
    drive_inputs();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_src();
    drive_inputs();
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (cnt[p] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run(input int budget, input string name);
    int n;
    n = 0;
    while ((pending() || busy || in_pkt) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("%s_finished", name), int'(n < budget), 1);
  endtask

  // Packet-level model: every port with queued packets requests at each arbitration.
  task automatic build_expected();
    int mh[NP];
    int mc[NP];
    int rr, k, f;
    pkt_t c;
    exp_port.delete(); exp_len.delete(); exp_first.delete();
    exp_und = 0; exp_ovr = 0; rr = 0;
    for (int p = 0; p < NP; p++) begin
      mh[p] = head[p];
      mc[p] = cnt[p];
    end
    forever begin
      k = -1;
      for (int off = 0; off < NP; off++)
        if (k < 0 && mc[(rr + off) % NP] > 0) k = (rr + off) % NP;
      if (k < 0) break;
      c = src[k][mh[k]];
      mh[k]++; mc[k]--;
      f = (c.drop > 0) ? c.drop : c.len;
      exp_port.push_back(k);
      exp_len.push_back((f < MAXL) ? f : MAXL);
      exp_first.push_back(c.base % 256);
      if (f >= MAXL && !(c.drop == 0 && c.len == MAXL)) exp_ovr++;
      if (c.drop > 0 && c.drop < MAXL) exp_und++;
      rr = (k + 1) % NP;
    end
  endtask

  task automatic compare_obs(input string name);
    int n;
    check($sformatf("%s_npkts", name), obs_port.size(), exp_port.size());
    n = (obs_port.size() < exp_port.size()) ? obs_port.size() : exp_port.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_port%0d", name, i), obs_port[i], exp_port[i]);
      check($sformatf("%s_len%0d", name, i), obs_len[i], exp_len[i]);
      check($sformatf("%s_first%0d", name, i), obs_first[i], exp_first[i]);
      check($sformatf("%s_contig%0d", name, i), obs_consec[i], 1);
    end
    check($sformatf("%s_underruns", name), und_cnt, exp_und);
    check($sformatf("%s_oversizes", name), ovr_cnt, exp_ovr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t2_exp[5];
    int nq, len, drop;
    t2_exp = '{0, 1, 2, 3, 0};

    //             port len drop base  fwd ovr und
    tbl[0] = '{0,  1,   0, 'h10,  1, 0, 0};
    tbl[1] = '{1, 12,   0, 'h20, 12, 0, 0};
    tbl[2] = '{2, 15,   0, 'h30, 15, 0, 0};
    tbl[3] = '{3, 16,   0, 'h40, 16, 0, 0};
    tbl[4] = '{3, 17,   0, 'h50, 16, 1, 0};
    tbl[5] = '{3, 20,   0, 'h60, 16, 1, 0};
    tbl[6] = '{1, 20,   5, 'h70,  5, 0, 1};
    tbl[7] = '{0, 20,  16, 'h80, 16, 1, 0};
    tbl[8] = '{2, 20,  15, 'hF8, 15, 0, 1};
    tbl[9] = '{1,  2,   1, 'h90,  1, 0, 1};

    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0;
    reset_dut();
    check("rst_grant", int'(grant), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_errs", int'({err_underrun, err_oversize}), 0);

    // Single packet: grant one cycle after valid, 12 contiguous bytes, then idle.
    load(0, 12, 0, 0);
    drive_inputs();
    tick();
    check("t1_grant", int'(grant), 'b0001);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t1_valid%0d", i), int'(m_valid), 1);
      check($sformatf("t1_data%0d", i), int'(m_data), i);
    end
    for (int i = 0; i < GAP + 1; i++) begin
      tick();
      check($sformatf("t1_idle%0d", i), int'(m_valid), 0);
    end
    run(100, "t1");

    for (int v = 0; v < 10; v++) begin
      reset_dut();
      load(tbl[v].port, tbl[v].len, tbl[v].drop, tbl[v].base);
      drive_inputs();
      run(200, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_npkts", v), obs_port.size(), 1);
      if (obs_port.size() > 0) begin
        check($sformatf("vec%0d_port", v), obs_port[0], tbl[v].port);
        check($sformatf("vec%0d_len", v), obs_len[0], tbl[v].fwd);
        check($sformatf("vec%0d_first", v), obs_first[0], tbl[v].base);
        check($sformatf("vec%0d_contig", v), obs_consec[0], 1);
      end
      check($sformatf("vec%0d_ovr", v), ovr_cnt, tbl[v].ovr);
      check($sformatf("vec%0d_und", v), und_cnt, tbl[v].und);
      check($sformatf("vec%0d_consumed", v), cnt[tbl[v].port], 0);
      if (tbl[v].ovr != 0) check($sformatf("vec%0d_ovr_at", v), ovr_at_len, MAXL);
    end

    // Round-robin across four requesters.
    reset_dut();
    load(0, 4, 0, 'h00); load(0, 4, 0, 'h08);
    load(1, 4, 0, 'h10); load(2, 4, 0, 'h20); load(3, 4, 0, 'h30);
    drive_inputs();
    run(300, "t2");
    check("t2_npkts", obs_port.size(), 5);
    for (int i = 0; i < 5 && i < obs_port.size(); i++) begin
      check($sformatf("t2_grant%0d", i), obs_port[i], t2_exp[i]);
      check($sformatf("t2_len%0d", i), obs_len[i], 4);
      check($sformatf("t2_contig%0d", i), obs_consec[i], 1);
    end

    // Underrun on port1, port2 served next.
    reset_dut();
    load(1, 20, 5, 'h40);
    load(2, 4, 0, 'hA0);
    drive_inputs();
    run(300, "t3");
    check("t3_npkts", obs_port.size(), 2);
    if (obs_port.size() == 2) begin
      check("t3_port_a", obs_port[0], 1);
      check("t3_len_a", obs_len[0], 5);
      check("t3_port_b", obs_port[1], 2);
      check("t3_len_b", obs_len[1], 4);
    end
    check("t3_und", und_cnt, 1);
    check("t3_ovr", ovr_cnt, 0);

    // Reset mid-packet.
    reset_dut();
    load(0, 10, 0, 'h20);
    load(1, 4, 0, 'h30);
    drive_inputs();
    tick();
    check("t5_grant0", int'(grant), 'b0001);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_m_valid", int'(m_valid), 0);
    check("t5_grant", int'(grant), 0);
    check("t5_s_ready", int'(s_ready), 0);
    check("t5_busy", int'(busy), 0);
    rst = 1'b0;
    clear_src();
    clear_mon();
    load(1, 4, 0, 'h30);
    load(0, 4, 0, 'h20);
    drive_inputs();
    tick();
    check("t5_regrant", int'(grant), 'b0001);
    run(200, "t5");

    // Back-to-back on port2: GAP cycles then one IDLE cycle before re-grant.
    reset_dut();
    load(2, 3, 0, 'h50);
    load(2, 3, 0, 'h60);
    drive_inputs();
    tick();
    check("t6_grant", int'(grant), 'b0100);
    for (int i = 0; i < 3; i++) tick();
    check("t6_gap1", int'({busy, grant}), 'b10000);
    tick();
    check("t6_gap2", int'({busy, grant}), 'b10000);
    tick();
    check("t6_idle", int'({busy, grant}), 'b00000);
    tick();
    check("t6_regrant", int'(grant), 'b0100);
    run(100, "t6");
    check("t6_npkts", obs_port.size(), 2);

    // Randomized traffic against the packet-level model.
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      for (int p = 0; p < NP; p++) begin
        nq = $urandom_range(0, 3);
        for (int q = 0; q < nq; q++) begin
          len  = $urandom_range(1, 22);
          drop = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
          load(p, len, drop, $urandom_range(0, 255));
        end
      end
      build_expected();
      drive_inputs();
      run(3000, $sformatf("rnd%0d", r));
      compare_obs($sformatf("rnd%0d", r));
    end

    check("inv_grant_onehot", viol_onehot, 0);
    check("inv_ready_subset", viol_ready, 0);
    check("inv_min_gap", viol_gap, 0);
    check("inv_pulse_width", viol_pulse, 0);
    check("inv_ovr_with_byte", viol_ovr_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
